// File: rtl/game_pkg.sv
// Shared encodings and default limits for the pong game-flow logic.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int WIN_SCORE_DEF   = 9;
    localparam int SERVE_TICKS_DEF = 60;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: pulses for one cycle when a synchronised level goes high.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // A level already high when reset releases yields an edge in the first cycle.
    assign rise = level & ~level_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Pong game-flow scheduler: START -> SERVE -> PLAY -> OVER, serve timing and scoring.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int SERVE_TICKS = SERVE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timing_tick,
    input  logic       start,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [1:0] state,
    output logic       ball_en,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic [3:0] player1_score,
    output logic [3:0] player2_score,
    output logic       winner
);

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_VAL = 8'(SERVE_TICKS);

    game_state_t state_r, state_nxt;
    logic [7:0]  cnt_r, cnt_nxt;
    logic [3:0]  p1_nxt, p2_nxt;
    logic [3:0]  p1_inc, p2_inc;
    logic        dir_nxt, win_nxt;
    logic        start_edge;

    edge_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (start),
        .rise  (start_edge)
    );

    assign p1_inc = player1_score + 4'd1;
    assign p2_inc = player2_score + 4'd1;

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        p1_nxt    = player1_score;
        p2_nxt    = player2_score;
        dir_nxt   = serve_dir;
        win_nxt   = winner;
        case (state_r)
            ST_START, ST_OVER: begin
                if (start_edge) begin
                    state_nxt = ST_SERVE;
                    cnt_nxt   = SERVE_VAL;
                    p1_nxt    = 4'd0;
                    p2_nxt    = 4'd0;
                    dir_nxt   = 1'b0;
                    win_nxt   = 1'b0;
                end
            end
            ST_SERVE: begin
                if (timing_tick) begin
                    if (cnt_r <= 8'd1) begin
                        state_nxt = ST_PLAY;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt_r - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // Simultaneous misses are a dead ball: re-serve without scoring.
                case ({miss_p1, miss_p2})
                    2'b10: begin
                        p2_nxt  = p2_inc;
                        dir_nxt = 1'b0;
                        if (p2_inc == WIN_VAL) begin
                            state_nxt = ST_OVER;
                            win_nxt   = 1'b1;
                        end else begin
                            state_nxt = ST_SERVE;
                            cnt_nxt   = SERVE_VAL;
                        end
                    end
                    2'b01: begin
                        p1_nxt  = p1_inc;
                        dir_nxt = 1'b1;
                        if (p1_inc == WIN_VAL) begin
                            state_nxt = ST_OVER;
                            win_nxt   = 1'b0;
                        end else begin
                            state_nxt = ST_SERVE;
                            cnt_nxt   = SERVE_VAL;
                        end
                    end
                    2'b11: begin
                        state_nxt = ST_SERVE;
                        cnt_nxt   = SERVE_VAL;
                    end
                    default: ;
                endcase
            end
            default: state_nxt = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_START;
            cnt_r         <= 8'd0;
            player1_score <= 4'd0;
            player2_score <= 4'd0;
            serve_dir     <= 1'b0;
            winner        <= 1'b0;
            ball_en       <= 1'b0;
            ball_rst      <= 1'b1;
        end else begin
            state_r       <= state_nxt;
            cnt_r         <= cnt_nxt;
            player1_score <= p1_nxt;
            player2_score <= p2_nxt;
            serve_dir     <= dir_nxt;
            winner        <= win_nxt;
            ball_en       <= (state_nxt == ST_PLAY);
            ball_rst      <= (state_nxt != ST_PLAY);
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with WIN_SCORE=3 and SERVE_TICKS=4.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       timing_tick = 1'b0;
    logic       start = 1'b0;
    logic       miss_p1 = 1'b0;
    logic       miss_p2 = 1'b0;
    logic [1:0] state;
    logic       ball_en, ball_rst, serve_dir, winner;
    logic [3:0] player1_score, player2_score;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl #(.WIN_SCORE(3), .SERVE_TICKS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .timing_tick   (timing_tick),
        .start         (start),
        .miss_p1       (miss_p1),
        .miss_p2       (miss_p2),
        .state         (state),
        .ball_en       (ball_en),
        .ball_rst      (ball_rst),
        .serve_dir     (serve_dir),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            timing_tick = 1'b1;
            step();
        end
        timing_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if ({ball_en, ball_rst} !== 2'b01) begin errors++; $display("FAIL reset_ball: got en=%b rst=%b want en=0 rst=1", ball_en, ball_rst); end
        checks++; if ({player1_score, player2_score, serve_dir, winner} !== 10'd0) begin errors++; $display("FAIL reset_scores: got p1=%0d p2=%0d dir=%b win=%b want all 0", player1_score, player2_score, serve_dir, winner); end
        rst_n = 1'b1;
        step();
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_start: got %0d want 0", state); end
    endtask

    task automatic test_serve();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (state !== 2'd2 || ball_rst !== 1'b1) begin errors++; $display("FAIL start_to_serve: got state=%0d rst=%b want 2/1", state, ball_rst); end
        tick_n(3);
        step();
        checks++; if (state !== 2'd2 || ball_en !== 1'b0) begin errors++; $display("FAIL three_ticks: got state=%0d en=%b want 2/0", state, ball_en); end
        tick_n(1);
        checks++; if (state !== 2'd1 || ball_en !== 1'b1 || ball_rst !== 1'b0) begin errors++; $display("FAIL fourth_tick: got state=%0d en=%b rst=%b want 1/1/0", state, ball_en, ball_rst); end
    endtask

    task automatic test_point();
        miss_p2 = 1'b1;
        step();
        miss_p2 = 1'b0;
        checks++; if (player1_score !== 4'd1 || player2_score !== 4'd0 || serve_dir !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL point_p1: got p1=%0d p2=%0d dir=%b state=%0d want 1/0/1/2", player1_score, player2_score, serve_dir, state); end
        miss_p1 = 1'b1;
        step();
        miss_p1 = 1'b0;
        checks++; if (player1_score !== 4'd1 || player2_score !== 4'd0 || state !== 2'd2) begin errors++; $display("FAIL miss_in_serve: got p1=%0d p2=%0d state=%0d want 1/0/2", player1_score, player2_score, state); end
        tick_n(4);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL reserve_play: got %0d want 1", state); end
    endtask

    task automatic test_both_miss();
        miss_p1 = 1'b1;
        miss_p2 = 1'b1;
        step();
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        checks++; if (player1_score !== 4'd1 || player2_score !== 4'd0 || serve_dir !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL both_miss: got p1=%0d p2=%0d dir=%b state=%0d want 1/0/1/2", player1_score, player2_score, serve_dir, state); end
        tick_n(4);
    endtask

    task automatic test_win();
        for (int i = 1; i <= 2; i++) begin
            miss_p1 = 1'b1;
            step();
            miss_p1 = 1'b0;
            checks++; if (player2_score !== 4'(i) || serve_dir !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL p2_point%0d: got p2=%0d dir=%b state=%0d want %0d/0/2", i, player2_score, serve_dir, state, i); end
            tick_n(4);
        end
        miss_p1 = 1'b1;
        step();
        miss_p1 = 1'b0;
        checks++; if (player2_score !== 4'd3 || state !== 2'd3 || winner !== 1'b1 || ball_rst !== 1'b1 || ball_en !== 1'b0) begin errors++; $display("FAIL game_over: got p2=%0d state=%0d win=%b rst=%b en=%b want 3/3/1/1/0", player2_score, state, winner, ball_rst, ball_en); end
        miss_p1 = 1'b1;
        miss_p2 = 1'b1;
        timing_tick = 1'b1;
        step();
        miss_p1 = 1'b0;
        step();
        miss_p2 = 1'b0;
        timing_tick = 1'b0;
        step();
        checks++; if (player1_score !== 4'd1 || player2_score !== 4'd3 || state !== 2'd3 || winner !== 1'b1) begin errors++; $display("FAIL over_frozen: got p1=%0d p2=%0d state=%0d win=%b want 1/3/3/1", player1_score, player2_score, state, winner); end
    endtask

    task automatic test_restart();
        start = 1'b1;
        step();
        checks++; if (state !== 2'd2 || player1_score !== 4'd0 || player2_score !== 4'd0 || winner !== 1'b0 || serve_dir !== 1'b0) begin errors++; $display("FAIL restart: got state=%0d p1=%0d p2=%0d win=%b dir=%b want 2/0/0/0/0", state, player1_score, player2_score, winner, serve_dir); end
        tick_n(2);
        start = 1'b1;
        for (int i = 0; i < 7; i++) step();
        start = 1'b0;
        tick_n(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL held_start_serve: got %0d want 2", state); end
        tick_n(1);
        checks++; if (state !== 2'd1 || ball_en !== 1'b1) begin errors++; $display("FAIL single_reload: got state=%0d en=%b want 1/1", state, ball_en); end
    endtask

    task automatic test_async_reset();
        miss_p2 = 1'b1;
        step();
        miss_p2 = 1'b0;
        tick_n(4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || ball_en !== 1'b0 || ball_rst !== 1'b1 || player1_score !== 4'd0) begin errors++; $display("FAIL async_reset: got state=%0d en=%b rst=%b p1=%0d want 0/0/1/0", state, ball_en, ball_rst, player1_score); end
        start = 1'b1;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL start_through_reset: got %0d want 2", state); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point();
        test_both_miss();
        test_win();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Game-flow scheduler for the pong datapath. Sequences ball logic and scoring through START -> SERVE -> PLAY -> OVER, gates ball motion on the per-frame timing_tick, and owns both players' scores. Sits between the ball/paddle logic (miss pulses) and the VGA overlay/UART link, which consume state, scores and winner.

Parameters:
WIN_SCORE, 9, score that ends the game (1..15)
SERVE_TICKS, 60, timing_tick pulses spent in SERVE before play resumes (1..255)

Ports:
clk  input  1  65 MHz system clock
rst_n  input  1  asynchronous, active-low reset
timing_tick  input  1  one-cycle pulse per frame
start  input  1  start/restart request, level, already synchronised to clk
miss_p1  input  1  one-cycle pulse: ball passed player1's edge (point to player2)
miss_p2  input  1  one-cycle pulse: ball passed player2's edge (point to player1)
state  output  2  current game state (package encoding)
ball_en  output  1  ball may move; high only in PLAY
ball_rst  output  1  hold ball at centre; high in START, SERVE, OVER
serve_dir  output  1  0 = serve toward player1, 1 = toward player2
player1_score  output  4  player1 points
player2_score  output  4  player2 points
winner  output  1  0 = player1, 1 = player2; valid in OVER

Behaviour:
- Reset (async, rst_n=0): state=ST_START, ball_en=0, ball_rst=1, serve_dir=0, scores=0, winner=0, serve counter=0, start_q=0. Takes effect immediately, mid-game included.
- All outputs registered; state/score/flag changes visible one clk after the triggering input cycle.
- start_edge = start & ~start_q; start_q registered. start held high through reset release gives one edge in the first cycle.
- ST_START: on start_edge -> ST_SERVE, scores cleared, serve_dir=0, counter=SERVE_TICKS.
- ST_SERVE: counter decrements on each timing_tick; tick with counter==1 -> ST_PLAY (exactly SERVE_TICKS ticks). miss_* and start ignored.
- ST_PLAY: ball_en=1, ball_rst=0. Next state from:
  - miss_p1 only: player2_score+1, serve_dir=0. New score == WIN_SCORE -> ST_OVER, winner=1; else -> ST_SERVE, counter=SERVE_TICKS.
  - miss_p2 only: player1_score+1, serve_dir=1. New score == WIN_SCORE -> ST_OVER, winner=0; else -> ST_SERVE.
  - both same cycle: no score change, serve_dir unchanged, -> ST_SERVE.
  - start_edge ignored.
- ST_OVER: scores and winner frozen. start_edge -> ST_SERVE, scores cleared, winner=0, serve_dir=0, counter=SERVE_TICKS.
- Scores never exceed WIN_SCORE; 4-bit unsigned, no wrap.
- miss_* outside PLAY: no effect.
- ball_en/ball_rst decoded from next state, registered with it (never both high).

Decomposition:
- Package game_pkg: typedef enum logic [1:0] game_state_t {ST_START=2'd0, ST_PLAY=2'd1, ST_SERVE=2'd2, ST_OVER=2'd3}; WIN_SCORE and SERVE_TICKS defaults as localparams for the top level.
- One sub-module: edge_detect (rising-edge detector, clk/rst_n), reused for start here and for button inputs elsewhere.
- FSM, serve counter and score registers stay in game_flow_ctrl.

Test Plan:
- Reset with start=0 -> state=0, ball_rst=1, ball_en=0, scores 0/0; assert rst_n=0 mid-PLAY -> same values same cycle.
- start pulse in START, SERVE_TICKS=4 -> state=2 next clk; after 4th timing_tick state=1, ball_en=1; 3 ticks alone keep SERVE.
- In PLAY pulse miss_p2 -> player1_score=1, serve_dir=1, state=2; miss_p1 in SERVE -> scores unchanged.
- WIN_SCORE=3: player2 scores 2, then miss_p1 -> player2_score=3, state=3, winner=1, ball_rst=1; further miss/tick no change.
- miss_p1 and miss_p2 same cycle in PLAY -> scores unchanged, state=2, serve_dir unchanged.
- In OVER hold start high 10 clks -> single restart: scores 0/0, winner=0, state=2, counter reloaded once.
